ilm_iter_mult: RTL

//  Parametrised sequential iterative logarithmic multiplier (ILM) for sign-magnitude operands.

---
 rtl/ilm_iter_mult.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ilm_iter_mult.sv
// rtl/ilm_iter_mult.sv - sequential iterative logarithmic multiplier, sign-magnitude operands
// Optional macro ILM_TRUNC_FLAG_EN adds out_trunc / out_iters status outputs.
module ilm_iter_mult #(
  parameter int W    = 8,
  parameter int ITER = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W:0]         in_a,
  input  logic [W:0]         in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_prod,
  output logic               out_sign
`ifdef ILM_TRUNC_FLAG_EN
  ,
  output logic               out_trunc,
  output logic [$clog2(W+1)-1:0] out_iters
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int TW = 2 * W;
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_mag_a;
  logic [W-1:0]    r_mag_b;
  logic            r_sign;
  logic [TW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;

  logic [KW-1:0]   w_k1;
  logic [KW-1:0]   w_k2;
  logic [KW:0]     w_ksum;
  logic [W-1:0]    w_q1;
  logic [W-1:0]    w_q2;
  logic [TW-1:0]   w_term;
  logic            w_stop;

  // Leading-one position of each residue; residues are nonzero whenever the term is used.
  always_comb begin
    w_k1 = '0;
    w_k2 = '0;
    for (int i = 0; i < W; i++) begin
      if (r_mag_a[i]) w_k1 = KW'(i);
      if (r_mag_b[i]) w_k2 = KW'(i);
    end
    w_ksum = {1'b0, w_k1} + {1'b0, w_k2};
    w_q1   = r_mag_a & ~(W'(1) << w_k1);
    w_q2   = r_mag_b & ~(W'(1) << w_k2);
    w_term = (TW'(1) << w_ksum) + (TW'(w_q1) << w_k2) + (TW'(w_q2) << w_k1);
    w_stop = (r_mag_a == '0) || (r_mag_b == '0) || (r_cnt == ITER_C);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_stop) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef ILM_TRUNC_FLAG_EN
  logic r_trunc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_sign  <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
`ifdef ILM_TRUNC_FLAG_EN
      r_trunc <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_mag_a <= in_a[W-1:0];
          r_mag_b <= in_b[W-1:0];
          r_sign  <= in_a[W] ^ in_b[W];
          r_acc   <= '0;
          r_cnt   <= '0;
`ifdef ILM_TRUNC_FLAG_EN
          r_trunc <= 1'b0;
`endif
        end
        S_RUN: if (!w_stop) begin
          r_acc   <= r_acc + w_term;
          r_mag_a <= w_q1;
          r_mag_b <= w_q2;
          r_cnt   <= r_cnt + CW'(1);
        end else begin
`ifdef ILM_TRUNC_FLAG_EN
          r_trunc <= (r_cnt == ITER_C) && (r_mag_a != '0) && (r_mag_b != '0);
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign out_prod  = r_acc;
  assign out_sign  = r_sign && (r_acc != '0);
`ifdef ILM_TRUNC_FLAG_EN
  assign out_trunc = r_trunc;
  assign out_iters = r_cnt;
`endif

endmodule
